req_arbiter_4ch: RTL and testbench
==================================

// Module: req_arbiter_4ch
// PURPOSE
//  Shares one downstream resource between four requesters. Requesters raise req[i]
//  and hold it for as long as they use the resource. The block issues a registered
//  one-hot grant, with round-robin or fixed priority selected by parameter. A hold
//  limit stops a single requester monopolising the resource.
//  It sits between requester blocks and the shared datapath, and drives the mux select.
// PARAMETERS
//  RR_EN     1  1 = round-robin from last owner+1; 0 = fixed priority, req[3] highest
//  MAX_HOLD  8  grant-tenure limit in cycles (>=2); applies only when others wait
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-high reset
//  req        in   4  request vector; req[i] held high while requester i uses resource
//  gnt        out  4  one-hot grant, registered; all-zero when no owner
//  gnt_id     out  2  binary index of owner; meaningful only when gnt_valid=1
//  gnt_valid  out  1  high iff gnt != 0
//  busy       out  1  high in GRANT and RELEASE states
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, busy=0, hold_cnt=0, last=2'd3.
//   - Reset is asynchronous and applies mid-grant too: outputs clear immediately, no drain.
//   - last=3 means req[0] wins first in RR mode.
//  FSM states:
//   - IDLE: if |req, latch winner into gnt/gnt_id and go to GRANT (gnt visible the
//     cycle after req is first sampled: 1-cycle latency); otherwise stay.
//   - GRANT: hold_cnt increments and saturates at MAX_HOLD.
//     - req[owner]==0 -> RELEASE (voluntary).
//     - hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0 -> RELEASE (preempt).
//     - Sole requester: never preempted; grant stays continuous.
//   - RELEASE: gnt=0, gnt_valid=0 for exactly one cycle; last<=owner; hold_cnt<=0;
//     go to IDLE. Minimum gap between two grants is 2 cycles (RELEASE + IDLE).
//  Arbitration (combinational on req, evaluated in IDLE only):
//   - RR: first set bit scanning last+1, last+2, ... mod 4.
//   - Fixed: highest set index.
//   - req changes during GRANT/RELEASE do not alter the owner except through the rules above.
//  Boundaries:
//   - Owner drops req in the same cycle preemption fires -> RELEASE (same outcome).
//   - req glitching to 0 in IDLE -> no grant.
//   - gnt is never multi-hot, and never changes owner without a zero cycle between owners.
//  Widths: hold_cnt is $clog2(MAX_HOLD+1) bits; last and gnt_id are 2 bits, wrapping mod 4.
// STRUCTURE
//  Shared package arb_pkg:
//   - state enum {ARB_IDLE, ARB_GRANT, ARB_RELEASE}
//   - localparam NUM_REQ=4
//   - function rotate4(vec, amt)
//  Sub-module arb_prio_enc4: combinational 4-to-2 priority encoder (highest index wins,
//   valid flag). Used twice:
//   - on the raw req vector, for fixed mode;
//   - on the req vector rotated by last+1, with the index un-rotated, for RR mode.
//  Top level holds the FSM, hold counter, last pointer and output registers.
// TESTING
//  1 reset, RR_EN=1, req=4'b0001 -> next cycle gnt=0001, gnt_id=0, gnt_valid=1, busy=1
//  2 RR_EN=1, MAX_HOLD=8, req=4'b1111 held -> owners 0,1,2,3,0; each gnt run is 8 cycles;
//    2 zero cycles between runs
//  3 RR_EN=0, req=4'b0101 held, MAX_HOLD=8 -> gnt_id=2 every run; req[0] never granted
//  4 req=0011; owner 0 drops req after 3 grant cycles -> RELEASE, IDLE, then gnt=0010
//  5 req=0100 alone held 20 cycles -> gnt=0100 continuous for 20 cycles, no zero cycle
//  6 async rst pulsed mid-GRANT (owner 2) -> gnt=0, busy=0 immediately; after release
//    with req=1111, RR grants id 0 first

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester arbiter.
//   arb_state_t : arbiter FSM states
//   NUM_REQ     : number of requesters served
//   rotate4     : rotate a 4-bit vector right, result[k] = vec[(k+amt) mod 4]
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [3:0] rotate4(input logic [3:0] vec, input logic [1:0] amt);
    logic [3:0] res;
    logic [1:0] src;
    res = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      src    = 2'(k) + amt;
      res[k] = vec[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_prio_enc4.sv
// Combinational 4-to-2 priority encoder, highest set index wins.
// Ports:
//   vec : input vector to encode
//   idx : index of the highest set bit (0 when vec is zero)
//   vld : high when any bit of vec is set
module arb_prio_enc4
  import arb_pkg::*;
(
  input  logic [3:0] vec,
  output logic [1:0] idx,
  output logic       vld
);

  always_comb begin
    idx = '0;
    vld = |vec;
    // Later iterations overwrite earlier ones, so the highest set bit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i]) idx = 2'(i);
    end
  end

endmodule

// File: rtl/req_arbiter_4ch.sv
// Four-requester arbiter with registered one-hot grant and a tenure limit.
// A requester holds req[i] high for as long as it uses the shared resource.
// Owners are chosen round-robin (RR_EN=1, starting after the previous owner)
// or by fixed priority (RR_EN=0, req[3] highest). An owner is forced off after
// MAX_HOLD cycles only while some other requester is waiting; every change of
// owner passes through at least two all-zero grant cycles.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req       : request vector, held high while requester uses resource
//   gnt       : registered one-hot grant, all-zero when no owner
//   gnt_id    : binary index of the owner, valid only when gnt_valid is high
//   gnt_valid : high whenever gnt is non-zero
//   busy      : high while the arbiter is granting or releasing
module req_arbiter_4ch
  import arb_pkg::*;
#(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       busy
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_SAT   = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD - 1);

  arb_state_t     state, state_n;
  logic [3:0]     gnt_n;
  logic [1:0]     gnt_id_n;
  logic [1:0]     last, last_n;
  logic [HCW-1:0] hold_cnt, hold_n;

  // Arbitration: both encoders look at req every cycle, the FSM only uses
  // the result in IDLE.
  logic [1:0] fx_idx, rr_idx, win;
  logic       fx_vld, rr_vld, any_req;
  logic [3:0] rr_rot, rr_vec;
  logic       waiting;

  // rr_rot[k] is the requester k+1 places after the previous owner. The
  // encoder favours high indices, so the vector is bit-reversed to make
  // the nearest candidate the strongest.
  always_comb begin
    rr_rot = rotate4(req, last + 2'd1);
    rr_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_vec[NUM_REQ-1-k] = rr_rot[k];
    end
  end

  arb_prio_enc4 u_enc_fixed (
    .vec (req),
    .idx (fx_idx),
    .vld (fx_vld)
  );

  arb_prio_enc4 u_enc_rr (
    .vec (rr_vec),
    .idx (rr_idx),
    .vld (rr_vld)
  );

  // Encoder position e corresponds to rotation offset 3-e, i.e. ~e, which
  // is added back onto last+1 to recover the real requester index.
  always_comb begin
    if (RR_EN != 0) begin
      win     = last + 2'd1 + ~rr_idx;
      any_req = rr_vld;
    end else begin
      win     = fx_idx;
      any_req = fx_vld;
    end
  end

  assign waiting = |(req & ~gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      last     <= last_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    last_n   = last;
    hold_n   = hold_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (any_req) begin
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          gnt_id_n   = win;
          hold_n     = '0;
          state_n    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        hold_n = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
        // The limit test is ">=" so that a requester arriving after the
        // counter has saturated (long sole ownership) still gets a turn.
        if (!req[gnt_id] || ((hold_cnt >= HOLD_LIMIT) && waiting)) begin
          gnt_n   = '0;
          last_n  = gnt_id;
          hold_n  = '0;
          state_n = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        hold_n  = '0;
        state_n = ARB_IDLE;
      end
      default: begin
        gnt_n   = '0;
        hold_n  = '0;
        state_n = ARB_IDLE;
      end
    endcase
  end

  assign gnt_valid = |gnt;
  assign busy      = (state == ARB_GRANT) || (state == ARB_RELEASE);

endmodule

// File: tb/tb_req_arbiter_4ch.sv
// Bench for req_arbiter_4ch: one round-robin and one fixed-priority instance
// share the same stimulus; a per-instance reference model feeds scoreboards
// that a negedge monitor drains, plus directed trace checks.
module tb_req_arbiter_4ch;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_rr, gnt_fx;
  logic [1:0] id_rr, id_fx;
  logic       val_rr, val_fx, busy_rr, busy_fx;

  req_arbiter_4ch #(.RR_EN(1), .MAX_HOLD(MAX_HOLD)) u_rr (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_rr), .gnt_id(id_rr), .gnt_valid(val_rr), .busy(busy_rr)
  );

  req_arbiter_4ch #(.RR_EN(0), .MAX_HOLD(MAX_HOLD)) u_fx (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_fx), .gnt_id(id_fx), .gnt_valid(val_fx), .busy(busy_fx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       busy;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fx[$];

  int checks   = 0;
  int failures = 0;

  // Model state per instance (0 = round robin, 1 = fixed priority):
  // owner (-1 none), cycles the grant has been visible, pending forced
  // zero cycle after a release, previous owner.
  int m_own[2];
  int m_held[2];
  int m_cool[2];
  int m_last[2];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int m, input logic [3:0] r, input int lst);
    if (m == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (lst + k) % 4;
        if (r[i]) return i;
      end
    end else begin
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m]  = -1;
      m_held[m] = 0;
      m_cool[m] = 0;
      m_last[m] = 3;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] r, output exp_t e);
    int waiting;
    if (m_own[m] >= 0) begin
      m_held[m]++;
      waiting = 0;
      for (int i = 0; i < 4; i++) if (i != m_own[m] && r[i]) waiting++;
      if (!r[m_own[m]] || (m_held[m] >= MAX_HOLD && waiting > 0)) begin
        m_last[m] = m_own[m];
        m_own[m]  = -1;
        m_cool[m] = 1;
      end
    end else if (m_cool[m] > 0) begin
      m_cool[m]--;
    end else if (r != 4'b0000) begin
      m_own[m]  = pick(m, r, m_last[m]);
      m_held[m] = 0;
    end
    e       = '0;
    if (m_own[m] >= 0) begin
      e.gnt[m_own[m]] = 1'b1;
      e.id            = 2'(m_own[m]);
      e.valid         = 1'b1;
    end
    e.busy = (m_own[m] >= 0) || (m_cool[m] > 0);
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [3:0] g,
                     input logic [1:0] id, input logic v, input logic b);
    check({tag, "_gnt"}, int'(g), int'(e.gnt));
    check({tag, "_valid"}, int'(v), int'(e.valid));
    check({tag, "_busy"}, int'(b), int'(e.busy));
    check({tag, "_onehot"}, int'($onehot0(g)), 1);
    if (e.valid) check({tag, "_id"}, int'(id), int'(e.id));
  endtask

  // Stimulus side: predict what each DUT shows after this edge.
  always @(posedge clk) begin
    exp_t e;
    if (!rst) begin
      model_step(0, req, e);
      q_rr.push_back(e);
      model_step(1, req, e);
      q_fx.push_back(e);
    end
  end

  always @(posedge rst) begin
    q_rr.delete();
    q_fx.delete();
    model_reset();
  end

  // Checking side.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_gnt_rr", int'(gnt_rr), 0);
      check("rst_valid_rr", int'(val_rr), 0);
      check("rst_busy_rr", int'(busy_rr), 0);
      check("rst_id_rr", int'(id_rr), 0);
      check("rst_gnt_fx", int'(gnt_fx), 0);
      check("rst_busy_fx", int'(busy_fx), 0);
    end else begin
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        cmp("sb_rr", e, gnt_rr, id_rr, val_rr, busy_rr);
      end
      if (q_fx.size() > 0) begin
        e = q_fx.pop_front();
        cmp("sb_fx", e, gnt_fx, id_fx, val_fx, busy_fx);
      end
    end
  end

  task automatic tick_obs();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int pos, run;
    model_reset();

    // 1: single request, one-cycle latency
    do_reset();
    req = 4'b0001;
    tick_obs();
    check("t1_gnt", int'(gnt_rr), 1);
    check("t1_id", int'(id_rr), 0);
    check("t1_valid", int'(val_rr), 1);
    check("t1_busy", int'(busy_rr), 1);
    check("t1_gnt_fx", int'(gnt_fx), 1);

    // 2: all requesting, round robin rotates in 8-cycle tenures, 2-cycle gaps
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 50; c++) begin
      tick_obs();
      pos = c % 10;
      run = c / 10;
      check("t2_rr_trace", int'(gnt_rr), (pos < 8) ? (1 << (run % 4)) : 0);
      check("t2_fx_trace", int'(gnt_fx), (pos < 8) ? 8 : 0);
    end

    // 3: fixed priority with 0101 always re-grants requester 2
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 40; c++) begin
      tick_obs();
      pos = c % 10;
      run = c / 10;
      check("t3_fx_trace", int'(gnt_fx), (pos < 8) ? 4 : 0);
      check("t3_rr_trace", int'(gnt_rr), (pos < 8) ? ((run % 2 == 0) ? 1 : 4) : 0);
    end

    // 4: voluntary release after 3 cycles, then the other requester
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick_obs();
      check("t4_own0", int'(gnt_rr), 1);
    end
    req = 4'b0010;
    tick_obs();
    check("t4_release_gnt", int'(gnt_rr), 0);
    check("t4_release_busy", int'(busy_rr), 1);
    tick_obs();
    check("t4_idle_gnt", int'(gnt_rr), 0);
    check("t4_idle_busy", int'(busy_rr), 0);
    tick_obs();
    check("t4_next_gnt", int'(gnt_rr), 2);
    check("t4_next_id", int'(id_rr), 1);

    // 5: sole requester is never preempted
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick_obs();
      check("t5_rr_cont", int'(gnt_rr), 4);
      check("t5_fx_cont", int'(gnt_fx), 4);
    end

    // 6: asynchronous reset mid-grant
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick_obs();
      check("t6_own2", int'(gnt_rr), 4);
    end
    rst = 1'b1;
    #1;
    check("t6_async_gnt", int'(gnt_rr), 0);
    check("t6_async_busy", int'(busy_rr), 0);
    check("t6_async_valid", int'(val_rr), 0);
    check("t6_async_gnt_fx", int'(gnt_fx), 0);
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_obs();
    check("t6_first_rr", int'(gnt_rr), 1);
    check("t6_first_id", int'(id_rr), 0);
    check("t6_first_fx", int'(gnt_fx), 8);

    // Random: sticky requests with occasional toggles and rare async resets.
    do_reset();
    req = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
